// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target core: FSM states, ACK/NACK
// bus levels and the per-byte bit counter.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BYTE_LAST = 4'd7;
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with edge, START and STOP event decode.
// Events are SYNC_STAGES+1 cycles behind the pins; no flow control.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   s_scl;

  // Preset to the idle bus level so reset release never looks like an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= s_scl;
      sda_prev_q <= sda_o;
    end
  end

  assign s_scl       = scl_sync_q[SYNC_STAGES-1];
  assign sda_o       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o  = s_scl & ~scl_prev_q;
  assign scl_fall_o  = ~s_scl & scl_prev_q;
  assign start_det_o = s_scl & sda_prev_q & ~sda_o;
  assign stop_det_o  = s_scl & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target serving a MEM_DEPTH-byte register file with auto-increment pointer.
// Host read port has 1-cycle latency; the bus master paces all I2C traffic.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h55,
  parameter int         MEM_DEPTH   = 16,
  parameter int         PTR_W       = $clog2(MEM_DEPTH),
  parameter int         SYNC_STAGES = 2
) (
  input  logic             i2c_core_clock_i,
  input  logic             i2c_core_reset_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             busy_o,
  output logic             wr_strobe_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  input  logic [PTR_W-1:0] host_addr_i,
  output logic [7:0]       host_rdata_o
);

  logic s_sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (i2c_core_clock_i),
    .rst_i      (i2c_core_reset_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (s_sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det)
  );

  state_t               state_q;
  logic [BIT_CNT_W-1:0] bitcnt_q;
  logic [7:0]           shift_q, rx_byte;
  logic                 rw_q, ptr_rcvd_q, sda_oe_q, busy_q, wr_strobe_q;
  logic [PTR_W-1:0]     ptr_q, ptr_inc, wr_addr_q;
  logic [7:0]           wr_data_q, host_rdata_q;
  logic [7:0]           mem_q [MEM_DEPTH];

  assign rx_byte = {shift_q[6:0], s_sda};
  assign ptr_inc = ptr_q + PTR_W'(1);

  always_ff @(posedge i2c_core_clock_i) begin
    if (i2c_core_reset_i) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      ptr_q        <= '0;
      ptr_rcvd_q   <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      host_rdata_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_strobe_q  <= 1'b0;
      host_rdata_q <= mem_q[host_addr_i];
      if (stop_det) begin
        state_q    <= IDLE;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        ptr_rcvd_q <= 1'b0;
      end else if (start_det) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR: if (scl_rise) begin
            shift_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == BYTE_LAST) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_q <= ADDR_ACK;
                rw_q    <= rx_byte[0];
                busy_q  <= 1'b1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          // First SCL fall pulls SDA for the ACK, the second one ends the ACK slot.
          ADDR_ACK, PTR_ACK, WRITE_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= '0;
              if (state_q == ADDR_ACK && rw_q) begin
                sda_oe_q <= ~mem_q[ptr_q][7];
                shift_q  <= {mem_q[ptr_q][6:0], 1'b0};
                bitcnt_q <= BIT_CNT_W'(1);
                state_q  <= READ;
              end else if (state_q == ADDR_ACK && !ptr_rcvd_q) begin
                state_q <= PTR;
              end else begin
                state_q <= WRITE;
              end
            end
          end
          PTR, WRITE: if (scl_rise) begin
            shift_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == BYTE_LAST) begin
              if (state_q == PTR) begin
                ptr_q      <= rx_byte[PTR_W-1:0];
                ptr_rcvd_q <= 1'b1;
                state_q    <= PTR_ACK;
              end else begin
                mem_q[ptr_q] <= rx_byte;
                wr_strobe_q  <= 1'b1;
                wr_addr_q    <= ptr_q;
                wr_data_q    <= rx_byte;
                ptr_q        <= ptr_inc;
                state_q      <= WRITE_ACK;
              end
            end
          end
          READ: if (scl_fall) begin
            if (bitcnt_q == BYTE_BITS) begin
              sda_oe_q <= 1'b0;
              state_q  <= READ_ACK;
            end else begin
              sda_oe_q <= ~shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b0};
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
          READ_ACK: if (scl_rise) begin
            ptr_q <= ptr_inc;
            unique case (s_sda)
              ACK: begin
                shift_q  <= mem_q[ptr_inc];
                bitcnt_q <= '0;
                state_q  <= READ;
              end
              NACK: state_q <= WAIT;
              default: state_q <= WAIT;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o     = sda_oe_q;
  assign busy_o       = busy_q;
  assign wr_strobe_o  = wr_strobe_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign host_rdata_o = host_rdata_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bit-banged I2C master driving i2c_slave_core, checked against a
// transaction-level register-file model.
module tb_i2c_slave_core;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr, host_addr;
  logic [7:0] wr_data, host_rdata;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_core dut (
    .i2c_core_clock_i(clk),
    .i2c_core_reset_i(rst),
    .scl_i           (scl_m),
    .sda_i           (sda_line),
    .sda_oe_o        (sda_oe),
    .busy_o          (busy),
    .wr_strobe_o     (wr_strobe),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data),
    .host_addr_i     (host_addr),
    .host_rdata_o    (host_rdata)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  mem_m [16];
  int          ptr_m = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [7:0]  tx_q[$];
  int          conf_hits = 0;
  logic [7:0]  conf_seen = 8'h00;

  always @(negedge clk) begin
    if (wr_strobe) begin
      got_q.push_back({wr_addr, wr_data});
      if (wr_addr == host_addr) begin
        conf_hits++;
        conf_seen = host_rdata;
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clk_bit(input logic b, output logic seen);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    seen = sda_line;
    wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(mack, s);
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1; wait_clks(Q);
      scl_m = 1'b1; wait_clks(Q);
    end
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(2 * Q);
  endtask

  task automatic check_strobes();
    check("strobe_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("strobe_addr_data", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_write(input logic [7:0] p);
    logic a;
    logic [7:0] b;
    i2c_start();
    send_byte(8'hAA, a); check("wr_addr_ack", 32'(a), 32'(0));
    check("wr_busy", 32'(busy), 32'(1));
    send_byte(p, a);     check("wr_ptr_ack", 32'(a), 32'(0));
    ptr_m = int'(p[3:0]);
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      send_byte(b, a);   check("wr_data_ack", 32'(a), 32'(0));
      exp_q.push_back({4'(ptr_m), b});
      mem_m[ptr_m] = b;
      ptr_m = (ptr_m + 1) % 16;
    end
    i2c_stop();
    check("wr_stop_busy", 32'(busy), 32'(0));
    check_strobes();
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hAA, a); check("rd_addr_ack", 32'(a), 32'(0));
    send_byte(p, a);     check("rd_ptr_ack", 32'(a), 32'(0));
    ptr_m = int'(p[3:0]);
    i2c_start();
    send_byte(8'hAB, a); check("rd_raddr_ack", 32'(a), 32'(0));
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      check("rd_data", 32'(d), 32'(mem_m[ptr_m]));
      ptr_m = (ptr_m + 1) % 16;
    end
    check("rd_wait_busy", 32'(busy), 32'(1));
    check("rd_wait_oe", 32'(sda_oe), 32'(0));
    i2c_stop();
    check("rd_stop_busy", 32'(busy), 32'(0));
  endtask

  logic       a0;
  logic [7:0] p0, d0, old0;

  initial begin
    host_addr = 4'd0;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;

    // Reset state
    wait_clks(4);
    check("rst_oe", 32'(sda_oe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_strobe", 32'(wr_strobe), 32'(0));
    check("rst_wr_addr", 32'(wr_addr), 32'(0));
    check("rst_wr_data", 32'(wr_data), 32'(0));
    check("rst_host_rdata", 32'(host_rdata), 32'(0));
    rst = 1'b0;
    wait_clks(4);
    check("post_rst_oe", 32'(sda_oe), 32'(0));

    // Directed write with a same-index host read during the write
    host_addr = 4'd3;
    old0 = mem_m[3];
    conf_hits = 0;
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h5A);
    do_write(8'h03);
    check("conflict_hits", 32'(conf_hits), 32'(1));
    check("conflict_old_byte", 32'(conf_seen), 32'(old0));
    host_addr = 4'd4;
    wait_clks(1);
    check("host_rdata_4", 32'(host_rdata), 32'(8'h5A));

    // Pointer, repeated START, read two bytes
    do_read(8'h03, 2);

    // Address mismatch: no ACK, later bytes ignored
    i2c_start();
    send_byte(8'hA8, a0); check("mismatch_nack", 32'(a0), 32'(1));
    check("mismatch_busy", 32'(busy), 32'(0));
    send_byte(8'h00, a0); check("mismatch_ignored", 32'(a0), 32'(1));
    i2c_stop();
    check_strobes();

    // Pointer wrap on write then read
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    do_write(8'h0F);
    do_read(8'h0F, 2);

    // STOP after four data bits
    p0 = 8'($urandom);
    i2c_start();
    send_byte(8'hAA, a0); check("midstop_addr_ack", 32'(a0), 32'(0));
    send_byte(p0, a0);    check("midstop_ptr_ack", 32'(a0), 32'(0));
    ptr_m = int'(p0[3:0]);
    for (int i = 0; i < 4; i++) clk_bit(1'($urandom), a0);
    i2c_stop();
    check_strobes();
    check("midstop_busy", 32'(busy), 32'(0));
    check("midstop_oe", 32'(sda_oe), 32'(0));
    i2c_start();
    send_byte(8'hAB, a0); check("midstop_raddr_ack", 32'(a0), 32'(0));
    recv_byte(1'b1, d0);
    check("midstop_ptr_kept", 32'(d0), 32'(mem_m[ptr_m]));
    ptr_m = (ptr_m + 1) % 16;
    i2c_stop();

    // Random write/read transactions
    for (int t = 0; t < 5; t++) begin
      p0 = 8'($urandom);
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) tx_q.push_back(8'($urandom));
      do_write(p0);
      do_read(8'($urandom), int'($urandom_range(1, 4)));
    end

    // Reset while the core is pulling SDA during a read
    tx_q.push_back(8'h0F);
    do_write(8'h09);
    i2c_start();
    send_byte(8'hAA, a0);
    send_byte(8'h09, a0);
    i2c_start();
    send_byte(8'hAB, a0); check("rstrd_raddr_ack", 32'(a0), 32'(0));
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    check("rstrd_oe_before", 32'(sda_oe), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstrd_oe_next_edge", 32'(sda_oe), 32'(0));
    wait_clks(2);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
    send_byte(8'hAA, a0); check("rstrd_no_response", 32'(a0), 32'(1));
    check("rstrd_busy", 32'(busy), 32'(0));
    i2c_stop();
    host_addr = 4'd9;
    wait_clks(1);
    check("rstrd_mem_cleared", 32'(host_rdata), 32'(0));
    check_strobes();
    p0 = 8'($urandom);
    tx_q.push_back(8'($urandom));
    tx_q.push_back(8'($urandom));
    do_write(p0);
    do_read(p0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
